cdb_arbiter_rr: RTL

//  Parametrised common-data-bus arbiter: NUM_FU functional-unit result ports share one CDB.

---
 rtl/rv32i_types.sv | 25 ++
 rtl/cdb_arbiter_rr_pick.sv | 44 ++++
 rtl/cdb_arbiter_rr.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types
// Shared types for the out-of-order core back end.
//   cdb_t      : one common-data-bus beat (valid qualifier, ROB tag, result)
//   arb_mode_t : CDB arbitration policy selector
//   CDB_MAX_FU : upper bound on the number of units sharing the CDB
// ---------------------------------------------------------------------------
package rv32i_types;

    localparam int CDB_MAX_FU = 8;
    localparam int ROB_TAG_W  = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      data;
    } cdb_t;

    typedef enum logic {
        ARB_RR  = 1'b0,
        ARB_TDM = 1'b1
    } arb_mode_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational circular priority picker.
// Searches i_req starting at i_base, wrapping past NUM_FU-1 back to 0,
// and returns the first requester found.
//   i_req   [NUM_FU] : request vector
//   i_base  [IDX_W]  : index with highest priority this cycle
//   o_grant [NUM_FU] : one-hot grant, zero when nobody requests
//   o_idx   [IDX_W]  : index of the granted requester (0 when none)
//   o_any            : a grant was made
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_FU = 3,
    parameter int IDX_W  = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0] i_req,
    input  logic [IDX_W-1:0]  i_base,
    output logic [NUM_FU-1:0] o_grant,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    // Walk the requesters in priority order; the first hit wins and
    // every later candidate is masked by o_any.
    always_comb begin
        int w_cand;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            w_cand = int'(i_base) + k;
            if (w_cand >= NUM_FU) begin
                w_cand = w_cand - NUM_FU;
            end
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = IDX_W'(w_cand);
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_rr
// Arbitrates NUM_FU functional-unit result latches onto one registered
// common data bus. Round-robin (ARB_MODE=0) or fixed slot rotation
// (ARB_MODE=1). After a branch flush, results are drained and the bus is
// held empty for FLUSH_CYCLES cycles, counting the flush cycle itself.
//   i_clk            : clock, rising edge
//   i_rst_n          : asynchronous reset, active low
//   i_fu_cdb[NUM_FU] : per-unit result, .valid is the request
//   i_flush          : branch mispredict flush
//   o_fu_ack[NUM_FU] : accept; unit i drops its result on the edge it is set
//   o_cdb            : registered broadcast, .valid qualifies it
//   o_busy           : squash window active
// ---------------------------------------------------------------------------
module cdb_arbiter_rr
    import rv32i_types::*;
#(
    parameter int NUM_FU       = 3,
    parameter int FLUSH_CYCLES = 3,
    parameter int ARB_MODE     = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  cdb_t              i_fu_cdb [NUM_FU],
    input  logic              i_flush,
    output logic [NUM_FU-1:0] o_fu_ack,
    output cdb_t              o_cdb,
    output logic              o_busy
);

    localparam int        IDX_W   = $clog2(NUM_FU);
    localparam arb_mode_t MODE    = arb_mode_t'(ARB_MODE == 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FU - 1);
    localparam logic [2:0]       SQ_LOAD  = 3'(FLUSH_CYCLES - 1);

    logic [IDX_W-1:0]  r_rrPtr;
    logic [IDX_W-1:0]  r_slot;
    logic [2:0]        r_sqCnt;
    cdb_t              r_cdb;

    logic [NUM_FU-1:0] w_req;
    logic [NUM_FU-1:0] w_rrGrant;
    logic [IDX_W-1:0]  w_rrIdx;
    logic              w_rrAny;
    logic [NUM_FU-1:0] w_grant;
    logic [IDX_W-1:0]  w_gIdx;
    logic              w_gAny;
    logic              w_squash;

    // Gather the request bits out of the result structs.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_req[i] = i_fu_cdb[i].valid;
        end
    end

    rr_pick #(
        .NUM_FU (NUM_FU),
        .IDX_W  (IDX_W)
    ) u_pick (
        .i_req   (w_req),
        .i_base  (r_rrPtr),
        .o_grant (w_rrGrant),
        .o_idx   (w_rrIdx),
        .o_any   (w_rrAny)
    );

    assign w_squash = i_flush || (r_sqCnt != 3'd0);

    // Mode mux: in slot mode only the slot owner may win, and only if it
    // is actually presenting a result.
    always_comb begin
        w_grant = '0;
        w_gIdx  = '0;
        w_gAny  = 1'b0;
        if (MODE == ARB_TDM) begin
            w_gIdx = r_slot;
            w_gAny = w_req[r_slot];
            if (w_req[r_slot]) begin
                w_grant[r_slot] = 1'b1;
            end
        end else begin
            w_grant = w_rrGrant;
            w_gIdx  = w_rrIdx;
            w_gAny  = w_rrAny;
        end
    end

    // While squashing every pending result is acked so the units drain
    // their stale latches. Outputs are gated by reset so they clear the
    // moment reset asserts rather than at the next edge.
    always_comb begin
        o_fu_ack = '0;
        o_busy   = 1'b0;
        if (i_rst_n) begin
            o_fu_ack = w_squash ? w_req : w_grant;
            o_busy   = w_squash;
        end
    end

    // Squash counter: a flush (re)loads the remaining window length, so
    // back-to-back flushes extend rather than stack.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sqCnt <= 3'd0;
        end else if (i_flush) begin
            r_sqCnt <= SQ_LOAD;
        end else if (r_sqCnt != 3'd0) begin
            r_sqCnt <= r_sqCnt - 3'd1;
        end
    end

    // Round-robin pointer moves just past the winner; it is frozen during
    // a squash so arbitration resumes where it left off. The slot rotates
    // unconditionally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rrPtr <= '0;
            r_slot  <= '0;
        end else begin
            r_slot <= (r_slot == LAST_IDX) ? '0 : r_slot + IDX_W'(1);
            if (MODE == ARB_RR && !w_squash && w_gAny) begin
                r_rrPtr <= (w_gIdx == LAST_IDX) ? '0 : w_gIdx + IDX_W'(1);
            end
        end
    end

    // Output register: loads the winner, or an empty beat when nobody won
    // or the window is squashing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cdb <= '0;
        end else if (!w_squash && w_gAny) begin
            r_cdb <= i_fu_cdb[w_gIdx];
        end else begin
            r_cdb <= '0;
        end
    end

    assign o_cdb = r_cdb;

endmodule
